// File: rtl/alu_driver_if.sv
// rtl/alu_driver_if.sv - request/response channel bundle between a requester and alu_driver
interface alu_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - request-side controller that decodes ALUOp/funct and sequences one ALU operation
module alu_driver #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_driver_if.slave      bus,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_mode,
  input  logic [31:0]      alu_res,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        dec_legal;
  logic [3:0]  dec_mode;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // Decode ALUOp/funct into the ALU mode; anything unlisted is flagged illegal.
  always_comb begin
    dec_mode  = 4'b0000;
    dec_legal = 1'b0;
    case (bus.req_aluop)
      2'b00: begin dec_mode = 4'b0010; dec_legal = 1'b1; end
      2'b01: begin dec_mode = 4'b0110; dec_legal = 1'b1; end
      2'b10: begin
        case (bus.req_funct)
          6'b100000: begin dec_mode = 4'b0010; dec_legal = 1'b1; end
          6'b100010: begin dec_mode = 4'b0110; dec_legal = 1'b1; end
          6'b100100: begin dec_mode = 4'b0000; dec_legal = 1'b1; end
          6'b100101: begin dec_mode = 4'b0001; dec_legal = 1'b1; end
          6'b100111: begin dec_mode = 4'b1100; dec_legal = 1'b1; end
          6'b101010: begin dec_mode = 4'b0111; dec_legal = 1'b1; end
          default:   begin dec_mode = 4'b0000; dec_legal = 1'b0; end
        endcase
      end
      default: begin dec_mode = 4'b0000; dec_legal = 1'b0; end
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: illegal requests skip the ALU and go straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dec_legal ? EXEC : RESP;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/mode registers change only on a legal accept so the ALU inputs stay quiet otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_mode <= 4'b0000;
    end else if (accept && dec_legal) begin
      alu_a    <= bus.req_a;
      alu_b    <= bus.req_b;
      alu_mode <= dec_mode;
    end
  end

  // Response capture and debug counters; the response is only written on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_q <= 32'd0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
    end else if (accept && !dec_legal) begin
      rsp_data_q <= 32'd0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b1;
      err_count  <= err_count + CNT_ONE;
    end else if (state_q == CAPT) begin
      rsp_data_q <= alu_res;
      rsp_zero_q <= alu_zero;
      rsp_err_q  <= 1'b0;
      op_count   <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with a behavioural ALU and reference model
module tb_alu_driver;

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic        err;
    logic [31:0] data;
    logic        zero;
    logic [3:0]  mode;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_mode;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [15:0] op_count;
  logic [15:0] err_count;

  int          checks;
  int          failures;
  int          exp_ops;
  int          exp_errs;
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [3:0]  last_mode;
  vec_t        vecs [10];

  alu_driver_if bus ();

  alu_driver #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .op_count  (op_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? a : b;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // ALU with one registered result stage
  always @(posedge clk) begin
    alu_res  <= alu_fn(alu_mode, alu_a, alu_b);
    alu_zero <= (alu_a == alu_b);
  end

  // Reference: name the operation, then compute result and expected mode from it
  function automatic vec_t make_vec(input logic [1:0] op, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b, input int dly);
    vec_t  v;
    string name;
    v.aluop = op; v.funct = f; v.a = a; v.b = b; v.delay = dly;
    name = "bad";
    if (op == 2'b00) name = "add";
    else if (op == 2'b01) name = "sub";
    else if (op == 2'b10) begin
      if (f == 6'd32) name = "add";
      else if (f == 6'd34) name = "sub";
      else if (f == 6'd36) name = "and";
      else if (f == 6'd37) name = "or";
      else if (f == 6'd39) name = "nor";
      else if (f == 6'd42) name = "min";
    end
    v.err = (name == "bad");
    v.zero = v.err ? 1'b0 : (a == b);
    v.mode = 4'd0;
    v.data = 32'd0;
    if (name == "add") begin v.data = a + b; v.mode = 4'd2; end
    if (name == "sub") begin v.data = a - b; v.mode = 4'd6; end
    if (name == "and") begin v.data = a & b; v.mode = 4'd0; end
    if (name == "or")  begin v.data = a | b; v.mode = 4'd1; end
    if (name == "nor") begin v.data = ~(a | b); v.mode = 4'd12; end
    if (name == "min") begin v.data = (int'(a) < int'(b)) ? a : b; v.mode = 4'd7; end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_flags"}, {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_mode"}, {28'd0, alu_mode}, 32'd0);
    chk({tag, "_counts"}, {op_count, err_count}, 32'd0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int          n;
    logic [31:0] held_data;
    logic [31:0] r;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_aluop = v.aluop;
    bus.req_funct = v.funct;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    r = $urandom;
    bus.req_a = r;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), v.err ? 32'd0 : 32'd2);
    if (v.err) exp_errs++;
    else begin
      exp_ops++;
      last_a = v.a;
      last_b = v.b;
      last_mode = v.mode;
    end
    chk({tag, "_data"}, bus.rsp_data, v.data);
    chk({tag, "_zero_err"}, {30'd0, bus.rsp_zero, bus.rsp_err}, {30'd0, v.zero, v.err});
    chk({tag, "_alu_mode"}, {28'd0, alu_mode}, {28'd0, last_mode});
    chk({tag, "_alu_ab"}, alu_a ^ alu_b, last_a ^ last_b);
    chk({tag, "_alu_a"}, alu_a, last_a);
    chk({tag, "_counts"}, {op_count, err_count}, {exp_ops[15:0], exp_errs[15:0]});
    held_data = bus.rsp_data;
    for (int d = 0; d < v.delay; d++) begin
      bus.req_valid = 1'b1;
      bus.req_aluop = 2'b11;
      @(negedge clk);
      chk({tag, "_bp_valid_ready"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
      chk({tag, "_bp_hold"}, {bus.rsp_data[31:2], bus.rsp_data[1:0] ^ {bus.rsp_zero, bus.rsp_err}},
          {held_data[31:2], held_data[1:0] ^ {v.zero, v.err}});
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_done_valid_ready"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; exp_ops = 0; exp_errs = 0;
    last_a = 32'd0; last_b = 32'd0; last_mode = 4'd0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_aluop = 2'b00; bus.req_funct = 6'd0;
    bus.req_a = 32'd0; bus.req_b = 32'd0; bus.rsp_ready = 1'b0;

    //            aluop   funct     a             b             dly err data          zero mode
    vecs[0] = '{2'b10, 6'b100000, 32'd5,        32'd7,        0, 0, 32'd12,       0, 4'b0010};
    vecs[1] = '{2'b01, 6'b000000, 32'd9,        32'd9,        1, 0, 32'd0,        1, 4'b0110};
    vecs[2] = '{2'b10, 6'b100111, 32'h0000FFFF, 32'h00FF0000, 0, 0, 32'hFF000000, 0, 4'b1100};
    vecs[3] = '{2'b10, 6'b101010, 32'd3,        32'd8,        0, 0, 32'd3,        0, 4'b0111};
    vecs[4] = '{2'b11, 6'b100000, 32'd1,        32'd2,        0, 1, 32'd0,        0, 4'b0111};
    vecs[5] = '{2'b10, 6'b000000, 32'd4,        32'd4,        2, 1, 32'd0,        0, 4'b0111};
    vecs[6] = '{2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1,        5, 0, 32'd0,        0, 4'b0010};
    vecs[7] = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 32'h00F000F0, 0, 4'b0000};
    vecs[8] = '{2'b10, 6'b100101, 32'hF0000000, 32'h0000000F, 0, 0, 32'hF000000F, 0, 4'b0001};
    vecs[9] = '{2'b10, 6'b100010, 32'd3,        32'd5,        1, 0, 32'hFFFFFFFE, 0, 4'b0110};

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the operation sits in CAPT
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_aluop = 2'b10; bus.req_funct = 6'b100000;
    bus.req_a = 32'd10; bus.req_b = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midop_reset");
    rst_n = 1'b1;
    exp_ops = 0; exp_errs = 0;
    last_a = 32'd0; last_b = 32'd0; last_mode = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midop_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_op(make_vec(2'b10, 6'b100000, 32'd100, 32'd23, 0), "after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rf;
      logic [5:0]  f;
      logic [1:0]  op;
      logic [5:0]  legal_f [6];
      legal_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rf = $urandom;
      op = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 3) == 0) ? rf[5:0] : legal_f[$urandom_range(0, 5)];
      run_op(make_vec(op, f, ra, rb, $urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
